audio_sample_conditioner: RTL and testbench

- Sits directly upstream of the HDMI audio input, in the core clock domain (clk32).
- Takes raw 18-bit signed core audio (L/R), applies a first-order low-pass, and decimates to RATE_HZ with a fractional phase accumulator.
- Saturates the result to 16 bits and applies volume/mute.
- Outputs a held 16-bit stereo word, a valid pulse and a toggle, so the pixel-clock domain can pick samples up safely.

---
 rtl/audio_cond_pkg.sv | 34 +++
 rtl/audio_sample_conditioner_lp.sv | 94 +++++++++
 rtl/audio_sample_conditioner.sv | 132 +++++++++++++
 tb/tb_audio_sample_conditioner.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_cond_pkg.sv
// Shared sample widths, volume encodings and saturation helpers for the
// audio sample conditioner.
package audio_cond_pkg;

  localparam int IN_W  = 18;
  localparam int MID_W = 17;
  localparam int OUT_W = 16;
  localparam int SAT_W = MID_W + 1;

  localparam logic [1:0] VOL_OFF     = 2'd0;
  localparam logic [1:0] VOL_QUARTER = 2'd1;
  localparam logic [1:0] VOL_HALF    = 2'd2;
  localparam logic [1:0] VOL_UNITY   = 2'd3;

  localparam logic signed [SAT_W-1:0] SAT_MAX = 18'sh07FFF;
  localparam logic signed [SAT_W-1:0] SAT_MIN = 18'sh38000;

  function automatic logic [OUT_W-1:0] sat16(input logic signed [SAT_W-1:0] v);
    logic [OUT_W-1:0] r;
    if (v > SAT_MAX) begin
      r = 16'h7FFF;
    end else if (v < SAT_MIN) begin
      r = 16'h8000;
    end else begin
      r = v[OUT_W-1:0];
    end
    return r;
  endfunction

  function automatic logic sat_clip(input logic signed [SAT_W-1:0] v);
    return (v > SAT_MAX) || (v < SAT_MIN);
  endfunction

endpackage

// File: rtl/audio_sample_conditioner_lp.sv
// One audio channel: first-order low-pass, tick capture and 16-bit saturation.
// Build option AUDIO_DC_BLOCK_EN inserts a tick-rate DC-blocking stage before saturation.
module audio_lp_channel
  import audio_cond_pkg::*;
#(
  parameter int IN_SHIFT = 1,
  parameter int LP_SHIFT = 4
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    in_valid_i,
  input  logic                    tick_i,
  input  logic signed [IN_W-1:0]  audio_i,
  output logic [OUT_W-1:0]        sat_o,
  output logic                    clip_o
);

  localparam int S_W = MID_W + LP_SHIFT;

  logic signed [MID_W-1:0] x_s;
  logic signed [MID_W-1:0] y_s;
  logic signed [S_W-1:0]   s_q;
  logic signed [S_W-1:0]   s_d;
  logic signed [SAT_W-1:0] pre_sat_s;
  logic                    sat_en_s;
  logic [OUT_W-1:0]        sat_q;
  logic                    clip_q;

  assign x_s = MID_W'(audio_i >>> IN_SHIFT);
  assign y_s = MID_W'(s_q >>> LP_SHIFT);

  always_comb begin
    s_d = s_q;
    if (in_valid_i) begin
      s_d = s_q + S_W'(x_s) - S_W'(y_s);
    end else begin
      s_d = s_q;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s_q <= {S_W{1'b0}};
    end else begin
      s_q <= s_d;
    end
  end

`ifdef AUDIO_DC_BLOCK_EN
  localparam int M_W = 27;

  logic signed [MID_W-1:0] ycap_q;
  logic                    cap_vld_q;
  logic signed [M_W-1:0]   m_q;

  // d = y - mean; the mean tracks y with a 2^-10 coefficient at the tick rate
  assign pre_sat_s = SAT_W'(ycap_q) - SAT_W'(m_q >>> 10);
  assign sat_en_s  = cap_vld_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ycap_q    <= {MID_W{1'b0}};
      cap_vld_q <= 1'b0;
      m_q       <= {M_W{1'b0}};
    end else begin
      cap_vld_q <= tick_i;
      if (tick_i) begin
        ycap_q <= y_s;
      end
      if (cap_vld_q) begin
        m_q <= m_q + M_W'(pre_sat_s);
      end
    end
  end
`else
  // y is taken from s_q, so a same-cycle in_valid update is not yet visible
  assign pre_sat_s = SAT_W'(y_s);
  assign sat_en_s  = tick_i;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sat_q  <= {OUT_W{1'b0}};
      clip_q <= 1'b0;
    end else if (sat_en_s) begin
      sat_q  <= sat16(pre_sat_s);
      clip_q <= sat_clip(pre_sat_s);
    end
  end

  assign sat_o  = sat_q;
  assign clip_o = clip_q;

endmodule

// File: rtl/audio_sample_conditioner.sv
// Stereo audio conditioner: low-pass, fractional-rate decimation, saturation, volume/mute.
// Build option AUDIO_DC_BLOCK_EN adds a DC-blocking stage (one extra cycle of latency).
module audio_sample_conditioner
  import audio_cond_pkg::*;
#(
  parameter int CLK_HZ   = 32000000,
  parameter int RATE_HZ  = 48000,
  parameter int ACC_W    = 32,
  parameter int IN_SHIFT = 1,
  parameter int LP_SHIFT = 4
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   in_valid,
  input  logic signed [IN_W-1:0] audio_l,
  input  logic signed [IN_W-1:0] audio_r,
  input  logic [1:0]             volume,
  input  logic                   mute,
  output logic [OUT_W-1:0]       out_l,
  output logic [OUT_W-1:0]       out_r,
  output logic                   out_valid,
  output logic                   out_toggle,
  output logic                   clip
);

  localparam logic [ACC_W-1:0] RATE_C = ACC_W'(RATE_HZ);
  localparam logic [ACC_W-1:0] CLK_C  = ACC_W'(CLK_HZ);

  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_d;
  logic [ACC_W-1:0] acc_sum_s;
  logic             tick_s;
  logic             s1_vld_q;
  logic             stage_vld_s;
  logic [OUT_W-1:0] sat_l_s;
  logic [OUT_W-1:0] sat_r_s;
  logic             clip_l_s;
  logic             clip_r_s;
  logic [OUT_W-1:0] out_l_q;
  logic [OUT_W-1:0] out_r_q;
  logic             out_valid_q;
  logic             out_toggle_q;
  logic             clip_q;

  function automatic logic [OUT_W-1:0] apply_vol(input logic [OUT_W-1:0] v,
                                                 input logic [1:0] vol,
                                                 input logic mute_en);
    logic signed [OUT_W-1:0] sv;
    logic [OUT_W-1:0]        r;
    sv = signed'(v);
    case (vol)
      VOL_OFF:     r = {OUT_W{1'b0}};
      VOL_QUARTER: r = sv >>> 2;
      VOL_HALF:    r = sv >>> 1;
      VOL_UNITY:   r = v;
      default:     r = {OUT_W{1'b0}};
    endcase
    return mute_en ? {OUT_W{1'b0}} : r;
  endfunction

  assign acc_sum_s = acc_q + RATE_C;

  // Phase accumulator wraps modulo CLK_HZ, giving exactly RATE_HZ ticks per CLK_HZ cycles
  always_comb begin
    acc_d  = acc_sum_s;
    tick_s = 1'b0;
    if (acc_sum_s >= CLK_C) begin
      acc_d  = acc_sum_s - CLK_C;
      tick_s = 1'b1;
    end else begin
      acc_d  = acc_sum_s;
      tick_s = 1'b0;
    end
  end

  audio_lp_channel #(.IN_SHIFT(IN_SHIFT), .LP_SHIFT(LP_SHIFT)) u_lp_l (
    .clk(clk), .resetn(resetn), .in_valid_i(in_valid), .tick_i(tick_s),
    .audio_i(audio_l), .sat_o(sat_l_s), .clip_o(clip_l_s)
  );

  audio_lp_channel #(.IN_SHIFT(IN_SHIFT), .LP_SHIFT(LP_SHIFT)) u_lp_r (
    .clk(clk), .resetn(resetn), .in_valid_i(in_valid), .tick_i(tick_s),
    .audio_i(audio_r), .sat_o(sat_r_s), .clip_o(clip_r_s)
  );

`ifdef AUDIO_DC_BLOCK_EN
  logic s1b_vld_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1b_vld_q <= 1'b0;
    end else begin
      s1b_vld_q <= s1_vld_q;
    end
  end

  assign stage_vld_s = s1b_vld_q;
`else
  assign stage_vld_s = s1_vld_q;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      acc_q        <= {ACC_W{1'b0}};
      s1_vld_q     <= 1'b0;
      out_l_q      <= {OUT_W{1'b0}};
      out_r_q      <= {OUT_W{1'b0}};
      out_valid_q  <= 1'b0;
      out_toggle_q <= 1'b0;
      clip_q       <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      s1_vld_q    <= tick_s;
      out_valid_q <= stage_vld_s;
      if (stage_vld_s) begin
        out_l_q      <= apply_vol(sat_l_s, volume, mute);
        out_r_q      <= apply_vol(sat_r_s, volume, mute);
        out_toggle_q <= ~out_toggle_q;
        clip_q       <= clip_l_s | clip_r_s;
      end else begin
        clip_q <= 1'b0;
      end
    end
  end

  assign out_l      = out_l_q;
  assign out_r      = out_r_q;
  assign out_valid  = out_valid_q;
  assign out_toggle = out_toggle_q;
  assign clip       = clip_q;

endmodule

// File: tb/tb_audio_sample_conditioner.sv
// Self-checking bench: two conditioner instances (LP_SHIFT 0 and 2) against an
// arithmetic reference model, plus directed reset, rate, saturation, volume and filter checks.
module tb_audio_sample_conditioner;

  logic        clk = 1'b0;
  logic        resetn;
  logic        in_valid;
  logic [17:0] audio_l;
  logic [17:0] audio_r;
  logic [1:0]  volume;
  logic        mute;
  logic [15:0] o0_l, o0_r, o2_l, o2_r;
  logic        o0_v, o0_t, o0_c, o2_v, o2_t, o2_c;

  int checks   = 0;
  int failures = 0;

  // reference model state
  longint m_s0l, m_s0r, m_s2l, m_s2r;
  int     m_cyc;
  bit     m_pv;
  longint m_p0l, m_p0r, m_p2l, m_p2r;
  bit     m_p0c, m_p2c;
  bit     e_v, e_t, e0c, e2c;
  longint e0l, e0r, e2l, e2r;

  int   since_rel, first_pulse, last_pulse, n_pulses, n_toggles;
  logic prev_tog;

  always #5 clk = ~clk;

  audio_sample_conditioner #(.CLK_HZ(1000), .RATE_HZ(48), .ACC_W(32), .IN_SHIFT(1), .LP_SHIFT(0)) dut0 (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .audio_l(audio_l), .audio_r(audio_r),
    .volume(volume), .mute(mute), .out_l(o0_l), .out_r(o0_r), .out_valid(o0_v),
    .out_toggle(o0_t), .clip(o0_c)
  );

  audio_sample_conditioner #(.CLK_HZ(1000), .RATE_HZ(48), .ACC_W(32), .IN_SHIFT(1), .LP_SHIFT(2)) dut2 (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .audio_l(audio_l), .audio_r(audio_r),
    .volume(volume), .mute(mute), .out_l(o2_l), .out_r(o2_r), .out_valid(o2_v),
    .out_toggle(o2_t), .clip(o2_c)
  );

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic longint fdiv(input longint a, input int sh);
    longint d;
    d = longint'(1) << sh;
    if (a >= 0) return a / d;
    else return -((-a + d - 1) / d);
  endfunction

  function automatic longint satv(input longint y);
    if (y > 32767) return 32767;
    else if (y < -32768) return -32768;
    else return y;
  endfunction

  function automatic bit clipv(input longint y);
    return (y > 32767) || (y < -32768);
  endfunction

  function automatic longint volv(input longint v, input logic [1:0] vol, input logic mu);
    longint r;
    if (vol == 2'd0) r = 0;
    else if (vol == 2'd1) r = fdiv(v, 2);
    else if (vol == 2'd2) r = fdiv(v, 1);
    else r = v;
    return mu ? 0 : r;
  endfunction

  // RATE ticks per CLK cycles: cycle n ticks when floor(n*RATE/CLK) steps up
  function automatic bit model_tick();
    return (((m_cyc + 1) * 48) / 1000) != ((m_cyc * 48) / 1000);
  endfunction

  task automatic model_reset();
    m_s0l = 0; m_s0r = 0; m_s2l = 0; m_s2r = 0; m_cyc = 0; m_pv = 1'b0;
    m_p0l = 0; m_p0r = 0; m_p2l = 0; m_p2r = 0; m_p0c = 1'b0; m_p2c = 1'b0;
    e_v = 1'b0; e_t = 1'b0; e0c = 1'b0; e2c = 1'b0;
    e0l = 0; e0r = 0; e2l = 0; e2r = 0;
  endtask

  task automatic release_reset();
    resetn = 1'b1;
    model_reset();
    since_rel = 0; first_pulse = -1; last_pulse = -1;
    n_pulses = 0; n_toggles = 0; prev_tog = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_v"}, longint'(o0_v | o2_v), 0);
    chk({tag, "_t"}, longint'(o0_t | o2_t), 0);
    chk({tag, "_c"}, longint'(o0_c | o2_c), 0);
    chk({tag, "_l"}, longint'(o0_l | o2_l), 0);
    chk({tag, "_r"}, longint'(o0_r | o2_r), 0);
  endtask

  task automatic reset_cycle();
    in_valid = 1'($urandom_range(0, 1));
    audio_l  = 18'($urandom);
    audio_r  = 18'($urandom);
    @(posedge clk);
    #1;
    chk_zero("rst");
  endtask

  // one clock: advance the model with this cycle's inputs, then compare after the edge
  task automatic cycle();
    bit     tk;
    longint xl, xr;
    tk = model_tick();
    if (m_pv) begin
      e_v = 1'b1; e_t = ~e_t;
      e0l = volv(m_p0l, volume, mute); e0r = volv(m_p0r, volume, mute);
      e2l = volv(m_p2l, volume, mute); e2r = volv(m_p2r, volume, mute);
      e0c = m_p0c; e2c = m_p2c;
    end else begin
      e_v = 1'b0; e0c = 1'b0; e2c = 1'b0;
    end
    m_pv = tk;
    if (tk) begin
      m_p0l = satv(m_s0l); m_p0r = satv(m_s0r);
      m_p0c = clipv(m_s0l) || clipv(m_s0r);
      m_p2l = satv(fdiv(m_s2l, 2)); m_p2r = satv(fdiv(m_s2r, 2));
      m_p2c = clipv(fdiv(m_s2l, 2)) || clipv(fdiv(m_s2r, 2));
    end
    if (in_valid) begin
      xl = fdiv(longint'($signed(audio_l)), 1);
      xr = fdiv(longint'($signed(audio_r)), 1);
      m_s0l = xl; m_s0r = xr;
      m_s2l = m_s2l + xl - fdiv(m_s2l, 2);
      m_s2r = m_s2r + xr - fdiv(m_s2r, 2);
    end
    m_cyc++;
    @(posedge clk);
    #1;
    since_rel++;
    chk("m0_valid", longint'(o0_v), longint'(e_v));
    chk("m0_toggle", longint'(o0_t), longint'(e_t));
    chk("m0_l", longint'($signed(o0_l)), e0l);
    chk("m0_r", longint'($signed(o0_r)), e0r);
    chk("m0_clip", longint'(o0_c), longint'(e0c));
    chk("m2_valid", longint'(o2_v), longint'(e_v));
    chk("m2_l", longint'($signed(o2_l)), e2l);
    chk("m2_r", longint'($signed(o2_r)), e2r);
    chk("m2_clip", longint'(o2_c), longint'(e2c));
    if (o0_v) begin
      n_pulses++;
      if (first_pulse < 0) first_pulse = since_rel;
      if (last_pulse >= 0)
        chk("spacing_20_21", longint'((since_rel - last_pulse == 20) || (since_rel - last_pulse == 21)), 1);
      last_pulse = since_rel;
    end
    if (o0_t !== prev_tog) n_toggles++;
    prev_tog = o0_t;
  endtask

  task automatic wait_valid(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      cycle();
      seen = o0_v;
    end
    chk({tag, "_seen"}, longint'(seen), 1);
  endtask

  task automatic settle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    longint fv[3];
    int     k;
    bit     got;
    resetn = 1'b0; in_valid = 1'b0; audio_l = 18'd0; audio_r = 18'd0;
    volume = 2'd3; mute = 1'b0;
    model_reset();

    for (int i = 0; i < 4; i++) reset_cycle();
    release_reset();

    // random stimulus over one full CLK period: rate, spacing and toggle count
    for (int i = 0; i < 1002; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      audio_l  = 18'($urandom);
      audio_r  = 18'($urandom);
      if ($urandom_range(0, 31) == 0) volume = 2'($urandom_range(0, 3));
      mute = ($urandom_range(0, 15) == 0);
      cycle();
    end
    chk("first_pulse_at_22", first_pulse, 22);
    chk("pulses_48", n_pulses, 48);
    chk("toggles_48", n_toggles, 48);

    // saturation on the bypassed filter
    in_valid = 1'b1; audio_l = 18'h1FFFF; audio_r = 18'h20000; volume = 2'd3; mute = 1'b0;
    settle(25);
    wait_valid("sat");
    chk("sat_l", longint'(o0_l), longint'(16'h7FFF));
    chk("sat_r", longint'(o0_r), longint'(16'h8000));
    chk("sat_clip", longint'(o0_c), 1);

    // volume and mute with x = 2000
    audio_l = 18'd4000; audio_r = 18'd0;
    settle(25);
    volume = 2'd3; wait_valid("vol3"); chk("vol3_l", longint'($signed(o0_l)), 2000);
    chk("vol3_noclip", longint'(o0_c), 0);
    volume = 2'd2; wait_valid("vol2"); chk("vol2_l", longint'($signed(o0_l)), 1000);
    volume = 2'd1; wait_valid("vol1"); chk("vol1_l", longint'($signed(o0_l)), 500);
    volume = 2'd0; wait_valid("vol0"); chk("vol0_l", longint'($signed(o0_l)), 0);
    volume = 2'd3; mute = 1'b1; wait_valid("mute"); chk("mute_l", longint'($signed(o0_l)), 0);
    mute = 1'b0;

    // reset one cycle after a tick drops the in-flight sample
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      cycle();
      got = m_pv;
    end
    chk("tick_found", longint'(got), 1);
    resetn = 1'b0;
    #1;
    chk_zero("midrst");
    for (int i = 0; i < 2; i++) reset_cycle();
    release_reset();

    // filter step, LP_SHIFT=2: in_valid only on tick cycles captures pre-update y
    audio_l = 18'd4000; audio_r = 18'd0; volume = 2'd3; mute = 1'b0;
    k = 0;
    for (int i = 0; i < 120 && k < 3; i++) begin
      in_valid = model_tick();
      cycle();
      if (o2_v) begin
        fv[k] = longint'($signed(o2_l));
        k++;
      end
    end
    chk("filt_count", k, 3);
    chk("first_pulse_after_midrst", first_pulse, 22);
    chk("filt_y0", fv[0], 0);
    chk("filt_y1", fv[1], 500);
    chk("filt_y2", fv[2], 875);

    // random tail
    for (int i = 0; i < 700; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      audio_l  = 18'($urandom);
      audio_r  = 18'($urandom);
      if ($urandom_range(0, 15) == 0) volume = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) mute = 1'($urandom_range(0, 1));
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
